// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with double-buffered value and anti-ghosting gaps.
// Optional leading-zero suppression: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl #(
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        load_i,
  input  logic [15:0] value_i,
  output logic        ready_o,
  output logic [6:0]  seven_seg_dig_o,
  output logic [3:0]  digit_en_o,
  output logic        frame_done_o
);

  localparam int CNT_MAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // state | meaning:  ST_BLANK | all digits off   ST_SHOW | digit idx_q lit
  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   pending_q, active_q;
  logic          ready_q, ready_d;
  logic [6:0]    dig_q, dig_d;
  logic [3:0]    en_q, en_d;
  logic          fd_q, fd_d;
  logic          frame_end;
  logic          digit_on;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: hex_decode = 7'b0111111;
      4'h1: hex_decode = 7'b0000110;
      4'h2: hex_decode = 7'b1011011;
      4'h3: hex_decode = 7'b1001111;
      4'h4: hex_decode = 7'b1100110;
      4'h5: hex_decode = 7'b1101101;
      4'h6: hex_decode = 7'b1111101;
      4'h7: hex_decode = 7'b0000111;
      4'h8: hex_decode = 7'b1111111;
      4'h9: hex_decode = 7'b1101111;
      4'hA: hex_decode = 7'b1110111;
      4'hB: hex_decode = 7'b1111100;
      4'hC: hex_decode = 7'b0111001;
      4'hD: hex_decode = 7'b1011110;
      4'hE: hex_decode = 7'b1111001;
      default: hex_decode = 7'b1110001;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_BLANK;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      pending_q <= 16'h0000;
      active_q  <= 16'h0000;
      ready_q   <= 1'b1;
      dig_q     <= 7'd0;
      en_q      <= 4'd0;
      fd_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dig_q   <= dig_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      if (load_i) pending_q <= value_i;
      // Active only swaps at a frame boundary so a frame never mixes two values.
      if (!enable_i || frame_end) active_q <= pending_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    frame_end = 1'b0;
    if (!enable_i) begin
      state_d = ST_BLANK;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == CW'(BLANK_CYC - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end
        end
        default: begin
          if (cnt_q == CW'(SHOW_CYC - 1)) begin
            state_d   = ST_BLANK;
            idx_d     = idx_q + 2'd1;
            cnt_d     = '0;
            frame_end = (idx_q == 2'd3);
          end
        end
      endcase
    end
    if (load_i)                       ready_d = 1'b0;
    else if (!enable_i || frame_end)  ready_d = 1'b1;
    else                              ready_d = ready_q;
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [3:0] lead_nz;
  always_comb begin
    lead_nz[3] = |active_q[15:12];
    lead_nz[2] = lead_nz[3] | (|active_q[11:8]);
    lead_nz[1] = lead_nz[2] | (|active_q[7:4]);
    lead_nz[0] = 1'b1;
    digit_on   = lead_nz[idx_q];
  end
`else
  assign digit_on = 1'b1;
`endif

  assign nibble = active_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    dig_d = 7'd0;
    en_d  = 4'd0;
    fd_d  = frame_end;
    if (enable_i && (state_q == ST_SHOW) && digit_on) begin
      en_d  = 4'b0001 << idx_q;
      dig_d = hex_decode(nibble);
    end
  end

  assign ready_o         = ready_q;
  assign seven_seg_dig_o = dig_q;
  assign digit_en_o      = en_q;
  assign frame_done_o    = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_seven_seg_scan_ctrl;
  localparam int SHOW  = 4;
  localparam int BLANK = 2;
  localparam int SLOT  = SHOW + BLANK;
  localparam int FRAME = 4 * SLOT;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam logic [6:0] SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  logic clk = 1'b0;
  logic rst, en, load;
  logic [15:0] value;
  logic ready, fd;
  logic [6:0] dig;
  logic [3:0] den;

  int checks = 0;
  int passes = 0;

  seven_seg_scan_ctrl #(.SHOW_CYC(SHOW), .BLANK_CYC(BLANK)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .load_i(load), .value_i(value),
    .ready_o(ready), .seven_seg_dig_o(dig), .digit_en_o(den), .frame_done_o(fd));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: position within the scan timeline decides what must be lit.
  bit          m_valid = 1'b0;
  int          m_pos;
  logic [15:0] m_pend, m_act;
  logic        m_ready, e_fd;
  logic [6:0]  e_dig;
  logic [3:0]  e_en;

  always @(posedge clk) begin
    int f, slot, off;
    bit last, shown;
    logic [15:0] upper;
    if (rst) begin
      m_pend = 16'h0; m_act = 16'h0; m_ready = 1'b1; m_pos = 0;
      e_dig = 7'd0; e_en = 4'd0; e_fd = 1'b0; m_valid = 1'b1;
    end else begin
      f = m_pos % FRAME;
      slot = f / SLOT;
      off = f % SLOT;
      last = (f == FRAME - 1);
      if (!en) begin
        e_dig = 7'd0; e_en = 4'd0; e_fd = 1'b0;
        m_act = m_pend;
        m_pos = 0;
        m_ready = !load;
      end else begin
        upper = m_act >> (4 * slot);
        shown = (off >= BLANK) && (!LZ || slot == 0 || upper != 16'h0);
        e_en  = shown ? (4'b0001 << slot) : 4'd0;
        e_dig = shown ? SEG[upper[3:0]] : 7'd0;
        e_fd  = last;
        if (last) m_act = m_pend;
        m_ready = load ? 1'b0 : (last ? 1'b1 : m_ready);
        m_pos++;
      end
      if (load) m_pend = value;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("seg", dig, e_dig);
      chk("digit_en", den, e_en);
      chk("frame_done", fd, e_fd);
      chk("ready", ready, m_ready);
      chk("onehot", $countones(den) <= 1, 1);
    end
  end

  task automatic tick(); @(negedge clk); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask
  task automatic wait_fd();
    int n = 0;
    while (!fd && n < 60) begin tick(); n++; end
    chk("fd_timeout", fd, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0;
    ticks(2);
    chk("rst_seg", dig, 0); chk("rst_en", den, 0); chk("rst_fd", fd, 0); chk("rst_ready", ready, 1);

    rst = 1'b0; en = 1'b1; load = 1'b1; value = 16'h12AF;
    tick(); load = 1'b0;
    chk("load_ready_low", ready, 0);
    wait_fd();
    chk("ready_at_fd", ready, 1);
    ticks(3);  chk("d0_seg", dig, 7'b1110001); chk("d0_en", den, 4'b0001);
    ticks(6);  chk("d1_seg", dig, 7'b1110111); chk("d1_en", den, 4'b0010);
    ticks(6);  chk("d2_seg", dig, 7'b1011011); chk("d2_en", den, 4'b0100);
    ticks(6);  chk("d3_seg", dig, 7'b0000110); chk("d3_en", den, 4'b1000);
    ticks(3);  chk("frame_len", fd, 1);

    ticks(5);
    load = 1'b1; value = 16'h0001; tick(); load = 1'b0;
    ticks(2);
    load = 1'b1; value = 16'h0002; tick(); load = 1'b0;
    chk("overwrite_ready", ready, 0);
    wait_fd();
    chk("ready_back", ready, 1);
    ticks(3); chk("last_wins_seg", dig, 7'b1011011); chk("last_wins_en", den, 4'b0001);

    for (int k = 0; k < 2; k++) begin
      wait_fd();
      tick(); n = 1;
      while (!fd && n < 60) begin tick(); n++; end
      chk("fd_period", n, FRAME);
    end

    ticks(16); chk("in_d2_slot", den, LZ ? 4'b0000 : 4'b0100);
    en = 1'b0; tick();
    chk("dis_seg", dig, 0); chk("dis_en", den, 0); chk("dis_fd", fd, 0);
    ticks(4);
    en = 1'b1; tick(); chk("reen_gap1", den, 0);
    tick(); chk("reen_gap2", den, 0);
    tick(); chk("reen_d0_en", den, 4'b0001); chk("reen_d0_seg", dig, 7'b1011011);

    load = 1'b1; value = 16'hBEEF; tick(); load = 1'b0;
    wait_fd();
    ticks(4); chk("beef_d0", dig, 7'b1110001);
    rst = 1'b1; tick();
    chk("rst_mid_seg", dig, 0); chk("rst_mid_en", den, 0); chk("rst_mid_ready", ready, 1);
    rst = 1'b0; ticks(3);
    chk("restart_seg", dig, 7'b0111111); chk("restart_en", den, 4'b0001);

    load = 1'b1; value = 16'h0070; tick(); load = 1'b0;
    wait_fd();
    ticks(3); chk("lz_d0", den, 4'b0001); chk("lz_d0_seg", dig, 7'b0111111);
    ticks(6); chk("lz_d1", den, 4'b0010); chk("lz_d1_seg", dig, 7'b0000111);
    ticks(6); chk("lz_d2", den, LZ ? 4'b0000 : 4'b0100);
    ticks(6); chk("lz_d3", den, LZ ? 4'b0000 : 4'b1000);
    ticks(5);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end
endmodule
